// File: rtl/discrete_gated_vco_bank.sv
// discrete_gated_vco_bank: NUM_CH gated VCO voices, each with an
// attack/sustain/release envelope that sets both amplitude and pitch.
// Voices are processed one per clock after each audio_clk_en, summed into a
// 20-bit accumulator, saturated and registered as one signed 16-bit sample.
// Voltage scale: 16384 = 12 V.
//
// Optional build macro: DISCRETE_VCO_DC_BLOCK_EN adds a one-pole DC blocker
// after saturation, costing one extra clock of latency.
//
// Ports:
//   clk           system clock
//   I_RSTn        asynchronous active-low reset
//   audio_clk_en  one-clock sample strobe (ignored while busy)
//   trigger       per-voice gate level, 1 = voice on
//   out           mixed signed 16-bit sample
//   busy          high while a voice sweep is in progress

module discrete_gated_vco_bank #(
   parameter int unsigned CLOCK_RATE  = 1000000,
   parameter int unsigned SAMPLE_RATE = 48000,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned ATTACK_STEP = 1024,
   parameter int unsigned DECAY_SHIFT = 6,
   parameter logic [23:0] BASE_INC    = 24'd43690,
   parameter logic [23:0] MOD_INC     = 24'd87381,
   parameter int unsigned HP_SHIFT    = 8
) (
   input  logic                     clk,
   input  logic                     I_RSTn,
   input  logic                     audio_clk_en,
   input  logic [NUM_CH-1:0]        trigger,
   output logic signed [15:0]       out,
   output logic                     busy
);

   localparam int unsigned ENV_W  = 15;
   localparam int unsigned PH_W   = 24;
   localparam int unsigned ACC_W  = 20;
   localparam int unsigned PROD_W = ENV_W + PH_W;
   localparam int unsigned SLOT_W = $clog2(NUM_CH + 2);
   localparam int unsigned VIDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ENV_W-1:0]       ENV_FULL = ENV_W'(16384);
   localparam logic signed [ACC_W-1:0] POS_MAX = 20'sd32767;
   localparam logic signed [ACC_W-1:0] NEG_MIN = -20'sd32768;

   // Elaboration-time parameter sanity checks
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("NUM_CH must be in 1..8");
   end
   if (CLOCK_RATE / SAMPLE_RATE < NUM_CH + 3) begin : g_bad_rate
      $error("CLOCK_RATE/SAMPLE_RATE must be at least NUM_CH+3");
   end
   if (HP_SHIFT < 1 || HP_SHIFT > 15) begin : g_bad_hp_shift
      $error("HP_SHIFT must be in 1..15");
   end

   typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_t;
   typedef enum logic [1:0] {SW_IDLE, SW_VOICE, SW_SAT, SW_HP} sweep_t;

   sweep_t                   sweep_q, sweep_d;
   logic [SLOT_W-1:0]        slot_q, slot_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [15:0]       out_d;
   logic                     busy_d;

   voice_t                   v_state [NUM_CH];
   logic [ENV_W-1:0]         v_env   [NUM_CH];
   logic [PH_W-1:0]          v_phase [NUM_CH];

`ifdef DISCRETE_VCO_DC_BLOCK_EN
   logic signed [15:0]       x_cur, x_cur_d, x_prev, x_prev_d, y_prev, y_prev_d;
   logic signed [ACC_W-1:0]  hp_sum;
`endif

   // Current-slot voice datapath
   logic [VIDX_W-1:0]        vidx;
   voice_t                   cur_st, new_st;
   logic [ENV_W-1:0]         cur_env, new_env, dec_amt, rel_env;
   logic [PH_W-1:0]          cur_ph, new_ph, inc;
   logic [31:0]              att_sum;
   logic [PROD_W-1:0]        prod;
   logic                     cur_trig, clr_ph;
   logic signed [ACC_W-1:0]  env_s, contrib;

   function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
      if (v > POS_MAX)      return 16'sh7fff;
      else if (v < NEG_MIN) return -16'sh8000;
      else                  return 16'(v);
   endfunction

   // Voice FSM and oscillator for the voice selected by the slot counter.
   // Gate changes take effect in the same slot: an attack step on gate-on,
   // one decay step on gate-off.
   always_comb begin
      vidx     = VIDX_W'(slot_q);
      cur_st   = v_state[vidx];
      cur_env  = v_env[vidx];
      cur_ph   = v_phase[vidx];
      cur_trig = trigger[vidx];
      new_st   = cur_st;
      new_env  = cur_env;
      clr_ph   = 1'b0;

      att_sum = 32'(cur_env) + 32'(ATTACK_STEP);
      dec_amt = ENV_W'(cur_env >> DECAY_SHIFT) + ENV_W'(1);
      rel_env = (dec_amt >= cur_env) ? '0 : cur_env - dec_amt;

      if (cur_st != V_SUSTAIN && cur_trig) begin
         // attack step (also entry from IDLE and retrigger from RELEASE)
         if (att_sum >= 32'(ENV_FULL)) begin
            new_env = ENV_FULL;
            new_st  = V_SUSTAIN;
         end else begin
            new_env = ENV_W'(att_sum);
            new_st  = V_ATTACK;
         end
      end else if (cur_st == V_SUSTAIN && cur_trig) begin
         new_env = ENV_FULL;
      end else if (cur_st == V_IDLE) begin
         new_env = '0;
         clr_ph  = 1'b1;
      end else begin
         // gate low in ATTACK/SUSTAIN/RELEASE: decay toward IDLE
         new_env = rel_env;
         if (rel_env == '0) begin
            new_st = V_IDLE;
            clr_ph = 1'b1;
         end else begin
            new_st = V_RELEASE;
         end
      end

      prod    = PROD_W'(new_env) * PROD_W'(MOD_INC);
      inc     = BASE_INC + PH_W'(prod >> 14);
      new_ph  = clr_ph ? '0 : cur_ph + inc;
      env_s   = signed'(ACC_W'(new_env));
      contrib = new_ph[PH_W-1] ? -env_s : env_s;
   end

`ifdef DISCRETE_VCO_DC_BLOCK_EN
   // y = x - x_prev + y_prev - y_prev/2^HP_SHIFT
   assign hp_sum = ACC_W'(x_cur) - ACC_W'(x_prev) + ACC_W'(y_prev) - ACC_W'(y_prev >>> HP_SHIFT);
`endif

   // Sweep sequencer: next state and registered-output next values
   always_comb begin
      sweep_d = sweep_q;
      slot_d  = slot_q;
      acc_d   = acc_q;
      out_d   = out;
`ifdef DISCRETE_VCO_DC_BLOCK_EN
      x_cur_d  = x_cur;
      x_prev_d = x_prev;
      y_prev_d = y_prev;
`endif
      unique case (sweep_q)
         SW_IDLE: begin
            if (audio_clk_en) begin
               sweep_d = SW_VOICE;
               slot_d  = '0;
            end
         end
         SW_VOICE: begin
            if (slot_q == '0) acc_d = contrib;
            else              acc_d = acc_q + contrib;
            if (slot_q == SLOT_W'(NUM_CH - 1)) sweep_d = SW_SAT;
            slot_d = slot_q + SLOT_W'(1);
         end
         SW_SAT: begin
`ifdef DISCRETE_VCO_DC_BLOCK_EN
            x_cur_d = sat16(acc_q);
            sweep_d = SW_HP;
            slot_d  = slot_q + SLOT_W'(1);
`else
            out_d   = sat16(acc_q);
            sweep_d = SW_IDLE;
`endif
         end
         default: begin
`ifdef DISCRETE_VCO_DC_BLOCK_EN
            out_d    = sat16(hp_sum);
            x_prev_d = x_cur;
            y_prev_d = sat16(hp_sum);
`endif
            sweep_d  = SW_IDLE;
         end
      endcase
      busy_d = (sweep_d != SW_IDLE);
   end

   // State, voice and output registers
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         sweep_q <= SW_IDLE;
         slot_q  <= '0;
         acc_q   <= '0;
         out     <= '0;
         busy    <= 1'b0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            v_state[i] <= V_IDLE;
            v_env[i]   <= '0;
            v_phase[i] <= '0;
         end
`ifdef DISCRETE_VCO_DC_BLOCK_EN
         x_cur  <= '0;
         x_prev <= '0;
         y_prev <= '0;
`endif
      end else begin
         sweep_q <= sweep_d;
         slot_q  <= slot_d;
         acc_q   <= acc_d;
         out     <= out_d;
         busy    <= busy_d;
         if (sweep_q == SW_VOICE) begin
            v_state[vidx] <= new_st;
            v_env[vidx]   <= new_env;
            v_phase[vidx] <= new_ph;
         end
`ifdef DISCRETE_VCO_DC_BLOCK_EN
         x_cur  <= x_cur_d;
         x_prev <= x_prev_d;
         y_prev <= y_prev_d;
`endif
      end
   end

endmodule

// File: tb/tb_discrete_gated_vco_bank.sv
// Directed bench for discrete_gated_vco_bank (NUM_CH=2, ATTACK_STEP=4096,
// default build). Expected samples are hand-derived from the envelope and
// phase recurrences in 2^14 units.
module tb_discrete_gated_vco_bank;

   localparam int NUM_CH = 2;

   logic                  clk = 1'b0;
   logic                  I_RSTn = 1'b0;
   logic                  audio_clk_en = 1'b0;
   logic [NUM_CH-1:0]     trigger = '0;
   logic signed [15:0]    out;
   logic                  busy;

   int checks = 0;
   int failures = 0;

   discrete_gated_vco_bank #(
      .NUM_CH(NUM_CH),
      .ATTACK_STEP(4096)
   ) dut (
      .clk(clk),
      .I_RSTn(I_RSTn),
      .audio_clk_en(audio_clk_en),
      .trigger(trigger),
      .out(out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // One strobe; returns final out, number of busy clocks and out seen on the
   // last busy clock. Optionally pulses the strobe again during the sweep.
   task automatic run_sample(input logic [NUM_CH-1:0] trig, input bit mid_strobe,
                             output logic signed [15:0] o, output int bcnt,
                             output logic signed [15:0] o_early);
      @(negedge clk);
      trigger      = trig;
      audio_clk_en = 1'b1;
      @(negedge clk);
      audio_clk_en = 1'b0;
      bcnt    = 0;
      o_early = out;
      while (busy === 1'b1 && bcnt < 16) begin
         bcnt++;
         audio_clk_en = (mid_strobe && bcnt == 1);
         o_early = out;
         @(negedge clk);
      end
      audio_clk_en = 1'b0;
      o = out;
   endtask

   task automatic test_reset();
      @(negedge clk);
      I_RSTn       = 1'b0;
      trigger      = '0;
      audio_clk_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out !== 16'sd0) begin failures++; $display("FAIL reset_out: out=%0d expected 0", out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
      I_RSTn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle();
      logic signed [15:0] o, oe;
      int bc;
      for (int n = 0; n < 100; n++) begin
         run_sample('0, 1'b0, o, bc, oe);
         checks++;
         if (o !== 16'sd0) begin failures++; $display("FAIL idle_out[%0d]: out=%0d expected 0", n, o); end
         checks++;
         if (bc != NUM_CH + 1) begin failures++; $display("FAIL idle_busy[%0d]: busy clocks=%0d expected %0d", n, bc, NUM_CH + 1); end
      end
   endtask

   // Voice 0 from IDLE: 4096, 8192, 12288, 16384 (SUSTAIN); phase stays below
   // 2^23 through sample 65 (8388542) and crosses it at sample 66 (8519613).
   task automatic test_attack();
      logic signed [15:0] o, oe, exp_o;
      int bc;
      for (int n = 1; n <= 66; n++) begin
         run_sample(2'b01, 1'b0, o, bc, oe);
         if (n <= 4)       exp_o = 16'(4096 * n);
         else if (n <= 65) exp_o = 16'sd16384;
         else              exp_o = -16'sd16384;
         checks++;
         if (o !== exp_o) begin failures++; $display("FAIL attack[%0d]: out=%0d expected %0d", n, o, exp_o); end
      end
   endtask

   // Gate off from SUSTAIN: 16384 -> 16127 with phase 8649313 (negative),
   // then strictly decreasing magnitude down to 0 and silence.
   task automatic test_release();
      logic signed [15:0] o, oe;
      int bc, prev, mag;
      bit done, bad;
      run_sample(2'b00, 1'b0, o, bc, oe);
      checks++;
      if (o !== -16'sd16127) begin failures++; $display("FAIL release_first: out=%0d expected -16127", o); end
      prev = 16127;
      done = 1'b0;
      bad  = 1'b0;
      for (int n = 0; n < 1000 && !done && !bad; n++) begin
         run_sample(2'b00, 1'b0, o, bc, oe);
         mag = (o < 0) ? -int'(o) : int'(o);
         checks++;
         if (!(mag < prev)) begin
            failures++; bad = 1'b1;
            $display("FAIL release_monotonic[%0d]: |out|=%0d expected below %0d", n, mag, prev);
         end
         prev = mag;
         if (mag == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin failures++; $display("FAIL release_to_zero: last |out|=%0d expected 0", prev); end
      for (int n = 0; n < 3; n++) begin
         run_sample(2'b00, 1'b0, o, bc, oe);
         checks++;
         if (o !== 16'sd0) begin failures++; $display("FAIL release_idle[%0d]: out=%0d expected 0", n, o); end
      end
   endtask

   // Both voices from phase 0 in lockstep: 8192, 16384, 24576, then the sum
   // 32768 clips to 32767; negative half clips to -32768.
   task automatic test_saturate();
      logic signed [15:0] o, oe, exp_o;
      int bc;
      for (int n = 1; n <= 67; n++) begin
         run_sample(2'b11, 1'b0, o, bc, oe);
         if (n <= 3)       exp_o = 16'(8192 * n);
         else if (n <= 65) exp_o = 16'sh7fff;
         else              exp_o = -16'sh8000;
         checks++;
         if (o !== exp_o) begin failures++; $display("FAIL saturate[%0d]: out=%0d expected %0d", n, o, exp_o); end
      end
   endtask

   // Attack 4096, gate off -> 4031, 3968, gate on -> 8064 (resumes from the
   // release level), then 12160 with an ignored mid-sweep strobe.
   task automatic test_retrigger();
      logic signed [15:0] o, oe;
      logic [1:0]         trig_v [4];
      logic signed [15:0] exp_v  [4];
      int bc;
      test_reset();
      trig_v = '{2'b01, 2'b00, 2'b00, 2'b01};
      exp_v  = '{16'sd4096, 16'sd4031, 16'sd3968, 16'sd8064};
      for (int n = 0; n < 4; n++) begin
         run_sample(trig_v[n], 1'b0, o, bc, oe);
         checks++;
         if (o !== exp_v[n]) begin failures++; $display("FAIL retrigger[%0d]: out=%0d expected %0d", n, o, exp_v[n]); end
      end
      run_sample(2'b01, 1'b1, o, bc, oe);
      checks++;
      if (bc != NUM_CH + 1) begin failures++; $display("FAIL mid_strobe_busy: busy clocks=%0d expected %0d", bc, NUM_CH + 1); end
      checks++;
      if (oe !== 16'sd8064) begin failures++; $display("FAIL mid_strobe_latency: early out=%0d expected 8064", oe); end
      checks++;
      if (o !== 16'sd12160) begin failures++; $display("FAIL mid_strobe_out: out=%0d expected 12160", o); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL mid_strobe_queued: busy=%b expected 0", busy); end
   endtask

   // Reset during slot 1 clears out and busy at once; next sweeps start clean.
   task automatic test_reset_mid_sweep();
      logic signed [15:0] o, oe;
      int bc;
      @(negedge clk);
      trigger      = 2'b01;
      audio_clk_en = 1'b1;
      @(negedge clk);
      audio_clk_en = 1'b0;
      @(negedge clk);
      I_RSTn = 1'b0;
      #1;
      checks++;
      if (out !== 16'sd0) begin failures++; $display("FAIL midreset_out: out=%0d expected 0", out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: busy=%b expected 0", busy); end
      @(negedge clk);
      I_RSTn = 1'b1;
      run_sample(2'b00, 1'b0, o, bc, oe);
      checks++;
      if (o !== 16'sd0) begin failures++; $display("FAIL postreset_out: out=%0d expected 0", o); end
      checks++;
      if (bc != NUM_CH + 1) begin failures++; $display("FAIL postreset_busy: busy clocks=%0d expected %0d", bc, NUM_CH + 1); end
      run_sample(2'b01, 1'b0, o, bc, oe);
      checks++;
      if (o !== 16'sd4096) begin failures++; $display("FAIL postreset_attack: out=%0d expected 4096", o); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_attack();
      test_release();
      test_saturate();
      test_retrigger();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
